// File: rtl/gold_scrambler_seq.sv
// CCSDS complex scrambling-sequence generator: Gold-code Rn symbols, LANES per beat,
// selectable code number via sequential x-register seek, restart every FRAME_LEN symbols.
module gold_scrambler_seq #(
  parameter int LANES     = 1,
  parameter int FRAME_LEN = 16200,
  parameter int CODE_W    = 18
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [CODE_W-1:0]  i_code_n,
  input  logic               i_stop,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [2*LANES-1:0] o_r,
  output logic               o_sof,
  output logic               o_eof,
  output logic               o_busy
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] EOF_CNT  = CNT_W'(FRAME_LEN - LANES);
  localparam logic [CNT_W-1:0] LANE_INC = CNT_W'(LANES);
  localparam logic [17:0]      X_INIT   = 18'h00001;
  localparam logic [17:0]      Y_INIT   = 18'h3FFFF;

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_RUN} state_t;

  state_t             state;
  logic [17:0]        x, y, x_seed, y_seed;
  logic [17:0]        x_adv, y_adv;
  logic [CODE_W-1:0]  seek_cnt;
  logic [CNT_W-1:0]   sym_cnt;
  logic               valid_q, busy_q;
  logic [2*LANES-1:0] r_lanes;

  function automatic logic [17:0] x_step(input logic [17:0] v);
    return {v[7] ^ v[0], v[17:1]};
  endfunction

  function automatic logic [17:0] y_step(input logic [17:0] v);
    return {v[10] ^ v[7] ^ v[5] ^ v[0], v[17:1]};
  endfunction

  function automatic logic [1:0] rn_of(input logic [17:0] xv, input logic [17:0] yv);
    logic zlo, zhi;
    zlo = xv[0] ^ yv[0];
    zhi = xv[4] ^ xv[6] ^ xv[15] ^ yv[5] ^ yv[6] ^ (^yv[15:8]);
    return {zhi, zlo};
  endfunction

  // Lane k sees the state k steps ahead; the state after the last lane is the next beat's start.
  always_comb begin : unroll
    logic [17:0] xv, yv;
    xv      = x;
    yv      = y;
    r_lanes = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      r_lanes[2*k +: 2] = rn_of(xv, yv);
      xv = x_step(xv);
      yv = y_step(yv);
    end
    x_adv = xv;
    y_adv = yv;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      x        <= X_INIT;
      y        <= Y_INIT;
      x_seed   <= X_INIT;
      y_seed   <= Y_INIT;
      seek_cnt <= '0;
      sym_cnt  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (i_stop) begin
      state   <= S_IDLE;
      sym_cnt <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (i_start) begin
      state    <= S_SEEK;
      seek_cnt <= i_code_n;
      x        <= X_INIT;
      y        <= Y_INIT;
      sym_cnt  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        S_SEEK: begin
          if (seek_cnt == '0) begin
            x_seed  <= x;
            y_seed  <= y;
            state   <= S_RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            x        <= x_step(x);
            seek_cnt <= seek_cnt - CODE_W'(1);
          end
        end
        S_RUN: begin
          if (i_ready) begin
            if (sym_cnt == EOF_CNT) begin
              x       <= x_seed;
              y       <= y_seed;
              sym_cnt <= '0;
            end else begin
              x       <= x_adv;
              y       <= y_adv;
              sym_cnt <= sym_cnt + LANE_INC;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_r     = valid_q ? r_lanes : '0;
  assign o_sof   = valid_q && (sym_cnt == '0);
  assign o_eof   = valid_q && (sym_cnt == EOF_CNT);

endmodule

// File: tb/tb_gold_scrambler_seq.sv
// Bench for gold_scrambler_seq: two configurations driven in lockstep, checked every cycle
// against a bit-sequence model of the x/y Gold sequences, plus directed literal checks.
module tb_gold_scrambler_seq;
  localparam int LA = 2, FA = 8, LB = 1, FB = 16, CW = 18;

  logic clk = 1'b0;
  logic rst_n, start, stop, ready;
  logic [CW-1:0] code;
  logic a_valid, a_sof, a_eof, a_busy;
  logic [2*LA-1:0] a_r;
  logic b_valid, b_sof, b_eof, b_busy;
  logic [2*LB-1:0] b_r;

  int checks = 0, failures = 0;
  int cyc = 0;

  gold_scrambler_seq #(.LANES(LA), .FRAME_LEN(FA), .CODE_W(CW)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_code_n(code), .i_stop(stop),
    .i_ready(ready), .o_valid(a_valid), .o_r(a_r), .o_sof(a_sof), .o_eof(a_eof), .o_busy(a_busy));

  gold_scrambler_seq #(.LANES(LB), .FRAME_LEN(FB), .CODE_W(CW)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_code_n(code), .i_stop(stop),
    .i_ready(ready), .o_valid(b_valid), .o_r(b_r), .o_sof(b_sof), .o_eof(b_eof), .o_busy(b_busy));

  always #5 clk = ~clk;

  // Sequences as bit streams: state at time t is bits t..t+17 of the stream.
  bit xb[512];
  bit yb[512];

  function automatic logic [1:0] rn_model(input int n, input int s);
    logic zlo, zhi;
    int t;
    t   = n + s;
    zlo = xb[t] ^ yb[s];
    zhi = xb[t+4] ^ xb[t+6] ^ xb[t+15] ^ yb[s+5] ^ yb[s+6];
    for (int j = 8; j <= 15; j++) zhi ^= yb[s+j];
    return {zhi, zlo};
  endfunction

  function automatic logic [7:0] lanes_model(input int n, input int s, input int lanes);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < lanes; k++) r[2*k +: 2] = rn_model(n, s + k);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Timeline model: valid begins n+1 cycles after the start edge; symbols indexed mod frame.
  bit m_act[2];
  int m_run_at[2], m_n[2], m_sym[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int lanes, fl;
      logic v, b, so, eo;
      logic [7:0] r;
      logic [31:0] got, exp;
      lanes = (i == 0) ? LA : LB;
      fl    = (i == 0) ? FA : FB;
      if (!rst_n) m_act[i] = 1'b0;
      v  = m_act[i] && (cyc >= m_run_at[i]);
      b  = m_act[i] && (cyc < m_run_at[i]);
      r  = v ? lanes_model(m_n[i], m_sym[i], lanes) : 8'h00;
      so = v && (m_sym[i] == 0);
      eo = v && (m_sym[i] == fl - lanes);
      exp = {20'h0, v, b, so, eo, r};
      if (i == 0) got = {20'h0, a_valid, a_busy, a_sof, a_eof, 4'h0, a_r};
      else        got = {20'h0, b_valid, b_busy, b_sof, b_eof, 6'h0, b_r};
      check(i == 0 ? "cyc_a" : "cyc_b", got, exp);
      if (!rst_n) begin
      end else if (stop) begin
        m_act[i] = 1'b0;
      end else if (start) begin
        m_act[i]    = 1'b1;
        m_n[i]      = int'(code);
        m_run_at[i] = cyc + int'(code) + 2;
        m_sym[i]    = 0;
      end else if (v && ready) begin
        m_sym[i] = (m_sym[i] + lanes) % fl;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    code  = CW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = b_busy ? 1 : 0;
    do begin
      tick();
      lat++;
      if (b_busy) busy_cnt++;
    end while (!b_valid && lat < 200);
  endtask

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : driver
    int lat, bc, mism;
    logic [2*LA-1:0] cap_r[12];
    logic cap_sof[12], cap_eof[12];

    for (int i = 0; i < 18; i++) begin
      xb[i] = (i == 0);
      yb[i] = 1'b1;
    end
    for (int i = 0; i + 18 < 512; i++) begin
      xb[i+18] = xb[i] ^ xb[i+7];
      yb[i+18] = yb[i] ^ yb[i+5] ^ yb[i+7] ^ yb[i+10];
    end

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b1; code = '0;
    check("pin_rn_0_0", 32'(rn_model(0, 0)), 32'd0);
    check("pin_rn_0_1", 32'(rn_model(0, 1)), 32'd1);
    check("pin_rn_0_2", 32'(rn_model(0, 2)), 32'd1);
    check("pin_rn_1_0", 32'(rn_model(1, 0)), 32'd1);
    check("pin_lanes2", 32'(lanes_model(0, 0, 2)), 32'h4);

    repeat (3) tick();
    check("reset_a", {27'h0, a_valid, a_busy, a_sof, a_eof, |a_r}, 32'd0);
    check("reset_b", {27'h0, b_valid, b_busy, b_sof, b_eof, |b_r}, 32'd0);
    rst_n = 1'b1;
    tick();

    pulse_start(0);
    wait_valid(lat, bc);
    check("lat_n0", lat, 1);
    check("b_beat0_r", 32'(b_r), 32'd0);
    check("b_beat0_sof", 32'(b_sof), 32'd1);
    check("a_beat0_r", 32'(a_r), 32'h4);
    tick();
    check("b_beat1_r", 32'(b_r), 32'd1);
    tick();
    check("b_beat2_r", 32'(b_r), 32'd1);

    pulse_start(1);
    wait_valid(lat, bc);
    check("lat_n1", lat, 2);
    check("busy_n1", bc, 2);
    check("b_n1_r", 32'(b_r), 32'd1);

    pulse_start(5);
    wait_valid(lat, bc);
    check("lat_n5", lat, 6);

    pulse_start(0);
    wait_valid(lat, bc);
    for (int i = 0; i < 12; i++) begin
      cap_r[i] = a_r; cap_sof[i] = a_sof; cap_eof[i] = a_eof;
      tick();
    end
    check("a_eof_beat2", 32'(cap_eof[2]), 32'd0);
    check("a_eof_beat3", 32'(cap_eof[3]), 32'd1);
    check("a_sof_beat4", 32'(cap_sof[4]), 32'd1);
    check("a_r_beat4", 32'(cap_r[4]), 32'(cap_r[0]));
    mism = 0;
    for (int i = 4; i < 12; i++) if (cap_r[i] !== cap_r[i-4]) mism++;
    check("a_frames_equal", mism, 0);

    pulse_start(0);
    wait_valid(lat, bc);
    repeat (5) tick();
    pulse_start(3);
    check("restart_busy", {30'h0, b_busy, b_valid}, 32'd2);
    wait_valid(lat, bc);
    check("lat_restart_n3", lat, 4);
    check("restart_sof", 32'(b_sof), 32'd1);

    pulse_start(10);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_seek", {30'h0, a_busy, a_valid}, 32'd0);
    repeat (15) tick();
    check("stop_idle", {30'h0, a_busy, a_valid}, 32'd0);

    pulse_start(0);
    wait_valid(lat, bc);
    ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ready = 1'b1;
    check("stop_pending", 32'(b_valid), 32'd0);

    pulse_start(2);
    wait_valid(lat, bc);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_run", {27'h0, b_valid, b_busy, b_sof, b_eof, |a_r}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 1500; i++) begin
      int r;
      r     = int'($urandom_range(0, 199));
      ready = ($urandom_range(0, 99) < 65);
      start = (r < 4) || (r == 7);
      stop  = (r >= 4 && r < 6) || (r == 7);
      rst_n = (r != 6);
      code  = CW'($urandom_range(0, 12));
      tick();
    end
    start = 1'b0; stop = 1'b0; rst_n = 1'b1; ready = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
